// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_mem
// Description : APB slave backed by a DEPTH x 32-bit register file. Each
//               transfer is latched in the setup phase and completes in the
//               access phase after an optional number of wait states.
//               Misaligned or out-of-range addresses complete with pslverr=1
//               and never touch the memory.
// Macro       : APB_SLV_WAIT_EN - when defined, WAIT_CYCLES wait states are
//               inserted per transfer; when undefined every transfer is
//               zero-wait and WAIT_CYCLES has no effect.
// Ports       : pclk    - clock, rising edge
//               preset  - asynchronous active-high reset
//               psel    - slave select
//               penable - access phase indicator
//               pwrite  - 1 = write, 0 = read
//               paddr   - byte address
//               pwdata  - write data
//               prdata  - read data (non-zero only in a good read completion)
//               pready  - transfer completion
//               pslverr - transfer error, qualified by pready
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_mem #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

`ifdef APB_SLV_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIM  = 32'(DEPTH * 4);
    localparam logic [3:0]  WAIT_LOAD = WAIT_EN ? 4'(WAIT_CYCLES) : 4'd0;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] addr_q,  addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];

    logic             xfer_err;
    logic [IDX_W-1:0] mem_idx;

    // Error and index are derived from the latched address so that paddr
    // changing during the access phase cannot alter the outcome.
    assign xfer_err = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIM);
    assign mem_idx  = addr_q[IDX_W+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                // penable without a setup phase is ignored here.
                if (psel && !penable) begin
                    state_d = ACCESS;
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    // Requester dropped the transfer: abandon it silently.
                    state_d = IDLE;
                end else if (penable) begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                        if (write_q && !xfer_err) begin
                            mem_d[mem_idx] = wdata_q;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            write_q <= 1'b0;
            wdata_q <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        pready  = (state_q == ACCESS) && psel && penable && (cnt_q == 4'd0);
        pslverr = pready && xfer_err;
        prdata  = 32'd0;
        if (pready && !write_q && !xfer_err) begin
            prdata = mem_q[mem_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_mem
// Description : Self-checking bench for apb_slave_mem. Directed scenarios
//               followed by randomized transfers, all compared against a
//               plain array model of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_apb_slave_mem;

    localparam int DEPTH       = 16;
    localparam int WAIT_CYCLES = 2;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAITS = WAIT_CYCLES;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [DEPTH];

    apb_slave_mem #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    initial forever #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= DEPTH * 4);
    endfunction

    // One complete APB transfer starting at the next falling edge; leaves
    // psel/penable high so a following call forms a back-to-back transfer.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int waits);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        #1 check("setup_pready", 32'(pready), 32'd0);
        @(negedge pclk);
        penable = 1'b1;
        waits = 0;
        #1;
        while (!pready && waits < 40) begin
            check("wait_pslverr", 32'(pslverr), 32'd0);
            check("wait_prdata", prdata, 32'd0);
            waits++;
            @(negedge pclk);
            #1;
        end
        rd  = prdata;
        err = pslverr;
    endtask

    // Transfer plus comparison against the model, then model update.
    task automatic do_xfer(input string tag, input bit wr, input logic [31:0] a,
                           input logic [31:0] d);
        logic [31:0] rd;
        logic        err;
        int          waits;
        bit          bad;
        logic [31:0] exp_rd;
        bad    = addr_bad(a);
        exp_rd = (wr || bad) ? 32'd0 : model[a / 4];
        xfer(wr, a, d, rd, err, waits);
        check({tag, "_waits"}, 32'(waits), 32'(EXP_WAITS));
        check({tag, "_err"}, 32'(err), 32'(bad));
        check({tag, "_rdata"}, rd, exp_rd);
        if (wr && !bad) model[a / 4] = d;
    endtask

    task automatic go_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    endtask

    initial begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
        preset = 1'b1;
        clear_model();
        #12;
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        // Release just after a rising edge so the next edge carries the setup.
        @(posedge pclk);
        #2 preset = 1'b0;

        do_xfer("rd_0c_after_rst", 1'b0, 32'h0C, 32'h0);
        go_idle(1);
        do_xfer("wr_08", 1'b1, 32'h08, 32'hDEADBEEF);
        do_xfer("rd_08", 1'b0, 32'h08, 32'h0);
        go_idle(1);

        // Out-of-range and misaligned writes must leave the memory untouched.
        do_xfer("wr_04", 1'b1, 32'h04, 32'h0BADF00D);
        do_xfer("wr_40_oor", 1'b1, 32'h40, 32'h12345678);
        do_xfer("wr_05_mis", 1'b1, 32'h05, 32'hFFFFFFFF);
        do_xfer("rd_04", 1'b0, 32'h04, 32'h0);
        do_xfer("rd_41_err", 1'b0, 32'h41, 32'h0);
        for (int i = 0; i < DEPTH; i++) do_xfer("rd_sweep", 1'b0, 32'(i * 4), 32'h0);
        go_idle(2);

        // Back-to-back writes then reads.
        do_xfer("b2b_wr0", 1'b1, 32'h00, 32'h1);
        do_xfer("b2b_wr1", 1'b1, 32'h04, 32'h2);
        do_xfer("b2b_rd0", 1'b0, 32'h00, 32'h0);
        do_xfer("b2b_rd1", 1'b0, 32'h04, 32'h0);

        // penable with psel in IDLE (no setup) is ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            #1 check("no_setup_pready", 32'(pready), 32'd0);
        end
        go_idle(1);

        // Abort: psel drops during the access phase; no write may happen.
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hCAFE0001;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        #1 check("abort_pready", 32'(pready), 32'd0);
        go_idle(1);
        do_xfer("rd_14_after_abort", 1'b0, 32'h14, 32'h0);
        go_idle(1);

        // Reset during the access phase discards the pending write.
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hA5A5A5A5;
        @(negedge pclk);
        penable = 1'b1;
        #1 preset = 1'b1;
        #1 check("midrst_pready", 32'(pready), 32'd0);
        check("midrst_prdata", prdata, 32'd0);
        psel = 1'b0; penable = 1'b0;
        clear_model();
        @(posedge pclk);
        #2 preset = 1'b0;
        do_xfer("rd_10_after_rst", 1'b0, 32'h10, 32'h0);
        do_xfer("rd_08_after_rst", 1'b0, 32'h08, 32'h0);
        go_idle(1);

        // Randomized traffic, mostly aligned, some misaligned/out of range.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 19)) * 4;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            do_xfer("rand", 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 2) == 0) go_idle($urandom_range(1, 2));
        end
        go_idle(1);
        for (int i = 0; i < DEPTH; i++) do_xfer("final_sweep", 1'b0, 32'(i * 4), 32'h0);
        go_idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
